// File: rtl/arbiter_rr_n_pkt.sv
// arbiter_rr_n_pkt: N-way round-robin merge into one registered output slot.
// Packet grant locking is compiled in when ARBITER_RR_N_PKT_LOCK_EN is defined.
module arbiter_rr_n_pkt #(
  parameter int N      = 4,
  parameter int DWIDTH = 16,
  parameter int IDW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_valid,
  input  logic [DWIDTH-1:0] in_data [N],
  input  logic [N-1:0]      in_last,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] next_ptr;
  logic           gnt_vld;
  logic           load;
  logic           xfer;

`ifdef ARBITER_RR_N_PKT_LOCK_EN
  logic           locked;
  logic [IDW-1:0] lock_id;
`endif

  assign load = !out_valid || out_ready;
  assign xfer = load && gnt_vld && reset;

  // Walk the rotated order backwards so the channel closest to ptr wins.
  always_comb begin
    logic [IDW-1:0] c;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = IDW'((int'(ptr) + k) % N);
      if (in_valid[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = c;
      end
    end
`ifdef ARBITER_RR_N_PKT_LOCK_EN
    if (locked) begin
      gnt_vld = in_valid[lock_id];
      gnt_idx = lock_id;
    end
`endif
  end

  assign next_ptr = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = xfer && (gnt_idx == IDW'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
      ptr       <= '0;
`ifdef ARBITER_RR_N_PKT_LOCK_EN
      locked    <= 1'b0;
      lock_id   <= '0;
`endif
    end else if (load) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= in_data[gnt_idx];
        out_last <= in_last[gnt_idx];
        out_id   <= gnt_idx;
`ifdef ARBITER_RR_N_PKT_LOCK_EN
        // Mid-packet beats pin the grant; the last beat releases and rotates.
        locked <= !in_last[gnt_idx];
        if (!in_last[gnt_idx]) lock_id <= gnt_idx;
        else                   ptr     <= next_ptr;
`else
        ptr <= next_ptr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rr_n_pkt.sv
// Bench for arbiter_rr_n_pkt: vector tables, packet sequences, randomized run
// against a cycle-level reference model, plus an N=3 wrap check.
module tb_arbiter_rr_n_pkt;
  localparam int N  = 4;
  localparam int DW = 16;
`ifdef ARBITER_RR_N_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  in_valid, in_last, in_ready;
  logic [DW-1:0] in_data [N];
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;

  logic [2:0]    v3, l3, r3;
  logic [DW-1:0] d3 [3];
  logic          ov3, ol3;
  logic [DW-1:0] od3;
  logic [1:0]    oid3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arbiter_rr_n_pkt #(.N(N), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_id(out_id), .out_ready(out_ready)
  );

  arbiter_rr_n_pkt #(.N(3), .DWIDTH(DW)) dut3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_data(d3),
    .in_last(l3), .in_ready(r3), .out_valid(ov3),
    .out_data(od3), .out_last(ol3), .out_id(oid3), .out_ready(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: arbitration state and the contents of the output slot.
  int            m_ptr, m_lid, m_oid, m_g;
  bit            m_lk, m_ov, m_ol;
  logic [DW-1:0] m_od;
  logic [N-1:0]  acc, rdy_seen;

  function automatic void model_reset();
    m_ptr = 0; m_lid = 0; m_lk = 0; m_ov = 0; m_ol = 0; m_oid = 0; m_od = '0;
  endfunction

  function automatic int model_grant();
    if (LOCK_EN && m_lk) return in_valid[m_lid] ? m_lid : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Inputs are already applied; check in_ready, clock once, check the slot.
  task automatic cycle();
    #1;
    if (!reset) model_reset();
    m_g = model_grant();
    acc = '0;
    if (reset && (!m_ov || out_ready) && m_g >= 0) acc[m_g] = 1'b1;
    rdy_seen = in_ready;
    chk("in_ready", 32'(rdy_seen), 32'(acc));
    @(posedge clk);
    if (reset && (!m_ov || out_ready)) begin
      if (m_g >= 0) begin
        m_ov = 1; m_od = in_data[m_g]; m_ol = in_last[m_g]; m_oid = m_g;
        if (LOCK_EN && !in_last[m_g]) begin m_lk = 1; m_lid = m_g; end
        else begin m_lk = 0; m_ptr = (m_g + 1) % N; end
      end else m_ov = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_last", 32'(out_last), 32'(m_ol));
      chk("out_id", 32'(out_id), 32'(m_oid));
    end
  endtask

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    int         oid;
  } vec_t;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] rdy;
    logic       ov;
    int         oid;
    logic       olast;
  } pk_t;

  typedef struct {
    logic [2:0] vld;
    logic [2:0] rdy;
    int         oid;
  } w3_t;

  initial begin
    vec_t tbl [15] = '{
      '{4'hF, 1'b1, 4'b0001, 1'b1, 0}, '{4'hF, 1'b1, 4'b0010, 1'b1, 1},
      '{4'hF, 1'b1, 4'b0100, 1'b1, 2}, '{4'hF, 1'b1, 4'b1000, 1'b1, 3},
      '{4'hF, 1'b1, 4'b0001, 1'b1, 0}, '{4'hF, 1'b1, 4'b0010, 1'b1, 1},
      '{4'hF, 1'b1, 4'b0100, 1'b1, 2}, '{4'hF, 1'b1, 4'b1000, 1'b1, 3},
      '{4'hF, 1'b0, 4'b0000, 1'b1, 3}, '{4'hF, 1'b0, 4'b0000, 1'b1, 3},
      '{4'hF, 1'b0, 4'b0000, 1'b1, 3}, '{4'hF, 1'b0, 4'b0000, 1'b1, 3},
      '{4'hF, 1'b0, 4'b0000, 1'b1, 3}, '{4'hF, 1'b1, 4'b0001, 1'b1, 0},
      '{4'hF, 1'b1, 4'b0010, 1'b1, 1}
    };
    w3_t w3 [4] = '{
      '{3'b010, 3'b010, 1}, '{3'b101, 3'b100, 2},
      '{3'b101, 3'b001, 0}, '{3'b111, 3'b010, 1}
    };
    pk_t pk [$];
    int  bt1;

`ifdef ARBITER_RR_N_PKT_LOCK_EN
    pk.push_back('{4'b0111, 4'b0010, 1'b1, 1, 1'b0});
    pk.push_back('{4'b0111, 4'b0010, 1'b1, 1, 1'b0});
    pk.push_back('{4'b0101, 4'b0000, 1'b0, 0, 1'b0});
    pk.push_back('{4'b0101, 4'b0000, 1'b0, 0, 1'b0});
    pk.push_back('{4'b0111, 4'b0010, 1'b1, 1, 1'b1});
    pk.push_back('{4'b0101, 4'b0100, 1'b1, 2, 1'b0});
`else
    pk.push_back('{4'b0111, 4'b0010, 1'b1, 1, 1'b0});
    pk.push_back('{4'b0111, 4'b0100, 1'b1, 2, 1'b0});
    pk.push_back('{4'b0111, 4'b0001, 1'b1, 0, 1'b0});
    pk.push_back('{4'b0111, 4'b0010, 1'b1, 1, 1'b0});
    pk.push_back('{4'b0111, 4'b0100, 1'b1, 2, 1'b0});
    pk.push_back('{4'b0111, 4'b0001, 1'b1, 0, 1'b0});
    pk.push_back('{4'b0111, 4'b0010, 1'b1, 1, 1'b1});
`endif

    in_valid = '1; in_last = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = 16'hA000 + 16'(i);
    v3 = '0; l3 = '1;
    for (int i = 0; i < 3; i++) d3[i] = 16'hB000 + 16'(i);
    model_reset();

    // Held in reset with every channel requesting.
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_id", 32'(out_id), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Fairness over single-beat packets, then backpressure and resume.
    foreach (tbl[t]) begin
      in_valid = tbl[t].vld; out_ready = tbl[t].ordy; in_last = '1;
      cycle();
      chk("tbl_in_ready", 32'(rdy_seen), 32'(tbl[t].rdy));
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[t].ov));
      chk("tbl_out_id", 32'(out_id), 32'(tbl[t].oid));
      chk("tbl_out_data", 32'(out_data), 32'h0000A000 + 32'(tbl[t].oid));
    end

    // Move ptr to channel 1, then run the packet sequence.
    in_valid = 4'b0001; in_last = '1; out_ready = 1'b1;
    cycle();
    bt1 = 0;
    foreach (pk[t]) begin
      in_valid = pk[t].vld;
      in_last  = {2'b00, (bt1 == 2), 1'b0};
      cycle();
      if (rdy_seen[1]) bt1++;
      chk("pkt_in_ready", 32'(rdy_seen), 32'(pk[t].rdy));
      chk("pkt_out_valid", 32'(out_valid), 32'(pk[t].ov));
      if (pk[t].ov) begin
        chk("pkt_out_id", 32'(out_id), 32'(pk[t].oid));
        chk("pkt_out_last", 32'(out_last), 32'(pk[t].olast));
      end
    end

    // Reset mid-stream: arbitration must restart at channel 0, unlocked.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    in_valid = '1; in_last = '0;
    cycle();
    chk("post_rst_grant", 32'(rdy_seen), 32'h1);

    // Randomized traffic; a pending beat is held until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] || acc[i]) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          in_data[i]  = 16'($urandom);
          in_last[i]  = ($urandom_range(0, 2) == 0);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) != 0);
      cycle();
    end

    // N=3 wrap from channel 2 back to 0, ptr then lands on 1.
    in_valid = '0; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    foreach (w3[t]) begin
      v3 = w3[t].vld;
      #1;
      chk("n3_in_ready", 32'(r3), 32'(w3[t].rdy));
      @(posedge clk); #1;
      chk("n3_out_valid", 32'(ov3), 32'h1);
      chk("n3_out_id", 32'(oid3), 32'(w3[t].oid));
      chk("n3_out_data", 32'(od3), 32'h0000B000 + 32'(w3[t].oid));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_n_pkt.md
# arbiter_rr_n_pkt

N-way round-robin arbiter with a registered output stage and packet-aware grant locking. It merges N valid/ready streams into one output stream and tags each beat with the source index. It is the parametrised successor of the two-input round-robin merge, for places in the engine where more than two producers, such as cores or FIFOs, feed one consumer. The registered output breaks the ready/valid timing path into the consumer.

## Interface
Parameters:
- N, default 4: number of input channels, ≥2.
- DWIDTH, default 16: data width per beat.
- IDW, default $clog2(N): width of out_id (derived, not overridden).

Ports:
- clk, input, 1: clock. One clock.
- reset, input, 1: reset is asynchronous and active-low (asserted at 0).
- in_valid, input, N: per-channel valid, bit i = channel i.
- in_data, input, unpacked [N-1:0] × DWIDTH: per-channel data.
- in_last, input, N: per-channel end-of-packet flag.
- in_ready, output, N: per-channel ready; at most one bit high.
- out_valid, output, 1: registered output valid.
- out_data, output, DWIDTH: registered output data.
- out_last, output, 1: registered end-of-packet flag.
- out_id, output, IDW: index of the channel that produced the beat.
- out_ready, input, 1: consumer ready.

## Operation
- Output slot: a single register.
  - load = !out_valid || out_ready.
  - On load with a granted channel: out_valid, out_data, out_last and out_id capture that channel's beat.
  - On load with no grant: out_valid ← 0.
  - Without load: all outputs hold.
- Arbitration state:
  - ptr (IDW bits): highest-priority channel.
  - locked (1 bit) and lock_id (IDW bits).
- Unlocked grant: the first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (cyclic, wraps modulo N).
- Locked grant: lock_id if in_valid[lock_id]=1, otherwise none. Other channels never win while locked.
- in_ready[i] = load && grant[i]. The path is combinational from out_ready and in_valid. in_ready must not depend on in_ready.
- Transfer on channel g: in_valid[g] && in_ready[g].
  - in_last[g]=0: locked ← 1, lock_id ← g, ptr unchanged.
  - in_last[g]=1: locked ← 0, ptr ← (g+1) mod N. Wrap from N-1 gives 0, including non-power-of-two N.
- A single-beat packet (in_last=1 on an unlocked grant) never sets locked.
- in_data of non-granted channels is ignored. Inputs must hold valid/data until accepted; the block does not check this.

## Timing
- Latency: 1 cycle. A beat accepted at edge k appears on out_* after edge k.
- Throughput: 1 beat/cycle with out_ready held high, including consecutive beats from different channels.
- Reset (reset=0), asynchronously:
  - out_valid=0, out_data=0, out_last=0, out_id=0.
  - ptr=0, locked=0, lock_id=0.
  - in_ready=0 while in reset.
- Reset mid-packet: lock and the buffered beat are discarded. After release, arbitration restarts from channel 0, unlocked.
- Simultaneous requests: exactly one grant per cycle. The channel equal to ptr wins if it is valid.
- Output held with out_ready=0: no in_ready asserted and the state is unchanged.
- Locked channel deasserts valid mid-packet: the output drains (out_valid→0 after the consumer takes the buffered beat). The lock persists indefinitely.

## Configuration
- ARBITER_RR_N_PKT_LOCK_EN
  - Defined: packet locking as above.
  - Undefined:
    - locked is tied to 0; every beat arbitrates independently.
    - ptr ← (g+1) mod N on every transfer.
    - in_last is passed through to out_last only.
    - Lock registers are not synthesised.

## Test plan
- Reset with N=4: hold reset=0 with all in_valid=1 → in_ready=0000 and out_valid=0. After release, the first grant goes to channel 0 and out_id=0 one cycle later.
- Fairness: N=4, all channels valid with single-beat packets, out_ready=1 for 8 cycles → out_id sequence 0,1,2,3,0,1,2,3 and out_data matches each source.
- Wrap with non-power-of-two N: N=3, ch2 and ch0 valid, ptr=2 → out_id 2 then 0, and ptr returns to 1.
- Packet lock (macro defined):
  - Stimulus: ch1 sends 3 beats (last on the 3rd); ch0 and ch2 are valid throughout; ch1 drops valid for 2 cycles mid-packet.
  - Expected: out_id=1 for all 3 beats, no ch0/ch2 grant during the gap, then ch2 is granted next.
- Backpressure: out_ready=0 for 5 cycles with a beat buffered → out_* stable, in_ready=0. After out_ready returns to 1, one beat per cycle resumes with no loss or duplication.
- Lock disabled (macro undefined): ch1 sends a 3-beat packet while ch0 and ch2 are valid → beats interleave in the order 1,2,0,1,… and out_last is asserted only on ch1's third beat.
